// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - pipeline-side bundle for the EX-stage multiply/divide unit
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busAEx;
  logic [WIDTH-1:0] busBEx;
  logic             mtHi;
  logic             mtLo;
  logic             mfReq;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stallReq;

  // Pipeline / ID-EX side drives requests and operands
  modport master (
    output start, op, busAEx, busBEx, mtHi, mtLo, mfReq,
    input  hi, lo, busy, done, stallReq
  );

  // Multiply/divide unit side
  modport slave (
    input  start, op, busAEx, busBEx, mtHi, mtLo, mfReq,
    output hi, lo, busy, done, stallReq
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO (optional MULDIV_EARLY_OUT_EN)
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  ex_muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     opa;       // |A|: multiplicand, or dividend kept for divide-by-zero
  logic [WIDTH-1:0]     opb;       // |B|: divisor
  logic [2*WIDTH-1:0]   acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic                 is_div;
  logic                 neg_q;     // negate product / quotient
  logic                 neg_r;     // negate remainder (sign of dividend)
  logic                 b_zero;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 signed_in;
  logic                 div_in;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 early;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     dividend_orig;

  // Operand conditioning at accept: magnitudes only for the signed ops
  always_comb begin
    signed_in = ~bus.op[0];
    div_in    = bus.op[1];
    sign_a    = signed_in & bus.busAEx[WIDTH-1];
    sign_b    = signed_in & bus.busBEx[WIDTH-1];
    mag_a     = sign_a ? (~bus.busAEx + 1'b1) : bus.busAEx;
    mag_b     = sign_b ? (~bus.busBEx + 1'b1) : bus.busBEx;
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Trivial results skip the iteration: zero divisor, or a zero multiply operand
  assign early = div_in ? (bus.busBEx == '0)
                        : ((bus.busAEx == '0) || (bus.busBEx == '0));
`else
  assign early = 1'b0;
`endif

  // One radix-2 step for each of multiply (shift-add) and divide (restoring)
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, opb};
    div_ok   = ~div_diff[WIDTH];
    div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                acc[WIDTH-2:0], div_ok};
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    prod_fix      = neg_q ? (~acc + 1'b1) : acc;
    quo_fix       = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix       = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    dividend_orig = neg_r ? (~opa + 1'b1) : opa;
  end

  // Control FSM with datapath registers and registered HI/LO/busy/done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa    <= mag_a;
            opb    <= mag_b;
            is_div <= div_in;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            b_zero <= (bus.busBEx == '0);
            cnt    <= '0;
            busy_q <= 1'b1;
            if (div_in)
              acc <= {{WIDTH{1'b0}}, mag_a};
            else if (early)
              acc <= '0;
            else
              acc <= {{WIDTH{1'b0}}, mag_b};
            state  <= early ? FIX : CALC;
          end else begin
            if (bus.mtHi) hi_q <= bus.busAEx;
            if (bus.mtLo) lo_q <= bus.busAEx;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!is_div) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            hi_q <= dividend_orig;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.stallReq = busy_q & (bus.mfReq | bus.start | bus.mtHi | bus.mtLo);

endmodule
